// File: rtl/mxu_pkg.sv
// Shared constants, state encoding and address helpers for the sequential
// matrix multiply unit.
package mxu_pkg;

   localparam logic [31:0] ADDR_CTRL   = 32'd0;
   localparam logic [31:0] ADDR_RSVD   = 32'd1;
   localparam logic [31:0] ADDR_A_BASE = 32'd2;
   localparam logic [31:0] ADDR_C_BASE = 32'd1;

   localparam int CTRL_START = 0;
   localparam int CTRL_ACC   = 1;
   localparam int CTRL_SGN   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MAT_A = 2'd0,
      MAT_B = 2'd1,
      MAT_C = 2'd2
   } mat_e;

   // B follows A in the write map; C has its own read map starting at 1.
   function automatic logic [31:0] mat_base(input int size, input mat_e which);
      logic [31:0] base;
      case (which)
         MAT_A:   base = ADDR_A_BASE;
         MAT_B:   base = ADDR_A_BASE + 32'(size * size);
         MAT_C:   base = ADDR_C_BASE;
         default: base = ADDR_A_BASE;
      endcase
      return base;
   endfunction

endpackage

// File: rtl/mxu_seq_if.sv
// Register bus between host and mxu_seq: byte-style writes, word reads, status.
interface mxu_seq_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] wdata;
   logic [31:0]       awaddr;
   logic              wready;
   logic [31:0]       araddr;
   logic              arready;
   logic [31:0]       rdata;
   logic              busy;
   logic              done;

   modport master (output wdata, awaddr, wready, araddr, arready,
                   input  rdata, busy, done);
   modport slave  (input  wdata, awaddr, wready, araddr, arready,
                   output rdata, busy, done);
endinterface

// File: rtl/mxu_mac.sv
// Combinational multiply of two elements, extended to the accumulator width.
module mxu_mac #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sgn,
   output logic [ACC_W-1:0]  prod
);
   localparam int PW = 2 * DATA_W;

   logic signed [PW-1:0] prod_s;
   logic        [PW-1:0] prod_u;

   // Both products are formed; sgn selects which one is extended.
   always_comb begin
      prod_s = PW'($signed(a)) * PW'($signed(b));
      prod_u = PW'(a) * PW'(b);
      if (sgn) begin
         prod = ACC_W'(prod_s);
      end else begin
         prod = ACC_W'(prod_u);
      end
   end
endmodule

// File: rtl/mxu_seq.sv
// Matrix multiply C = A*B (or C += A*B) using one MAC per cycle, k innermost.
module mxu_seq import mxu_pkg::*; #(
   parameter int SIZE   = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic     clk,
   input  logic     reset,
   mxu_seq_if.slave bus
);
   localparam int          N      = SIZE * SIZE;
   localparam int          CW     = $clog2(SIZE);
   localparam int          IW     = $clog2(N);
   localparam logic [31:0] A_BASE = mat_base(SIZE, MAT_A);
   localparam logic [31:0] B_BASE = mat_base(SIZE, MAT_B);
   localparam logic [31:0] C_BASE = mat_base(SIZE, MAT_C);
   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   a_q [N];
   logic [DATA_W-1:0]   a_d [N];
   logic [DATA_W-1:0]   b_q [N];
   logic [DATA_W-1:0]   b_d [N];
   logic [ACC_W-1:0]    c_q [N];
   logic [ACC_W-1:0]    c_d [N];
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
   logic                acc_mode_q, acc_mode_d, sgn_q, sgn_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [IW-1:0]       aik_s, bkj_s, cij_s;
   logic [ACC_W-1:0]    prod_s, sum_s;
   logic [2:0]          ctrl_s;

   mxu_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .a    (a_q[aik_s]),
      .b    (b_q[bkj_s]),
      .sgn  (sgn_q),
      .prod (prod_s)
   );

   // Operand/result indices and the running sum; k=0 seeds from C or zero.
   always_comb begin
      aik_s = IW'(int'(i_q) * SIZE + int'(k_q));
      bkj_s = IW'(int'(k_q) * SIZE + int'(j_q));
      cij_s = IW'(int'(i_q) * SIZE + int'(j_q));
      if (k_q == {CW{1'b0}}) begin
         sum_s = (acc_mode_q ? c_q[cij_s] : {ACC_W{1'b0}}) + prod_s;
      end else begin
         sum_s = acc_q + prod_s;
      end
      ctrl_s = 3'(bus.wdata);
   end

   // Next-state: bus writes only outside RUN, sequencing inside RUN, reads always.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      c_d        = c_q;
      acc_d      = acc_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      acc_mode_d = acc_mode_q;
      sgn_d      = sgn_q;
      rdata_d    = rdata_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.wready) begin
               if (bus.awaddr == ADDR_CTRL) begin
                  if (ctrl_s[CTRL_START]) begin
                     acc_mode_d = ctrl_s[CTRL_ACC];
                     sgn_d      = ctrl_s[CTRL_SGN];
                     i_d        = {CW{1'b0}};
                     j_d        = {CW{1'b0}};
                     k_d        = {CW{1'b0}};
                     state_d    = RUN;
                  end else begin
                     state_d = state_q;
                  end
               end else if (bus.awaddr >= A_BASE && bus.awaddr < A_BASE + 32'(N)) begin
                  a_d[IW'(bus.awaddr - A_BASE)] = bus.wdata;
               end else if (bus.awaddr >= B_BASE && bus.awaddr < B_BASE + 32'(N)) begin
                  b_d[IW'(bus.awaddr - B_BASE)] = bus.wdata;
               end else begin
                  state_d = state_q;
               end
            end else begin
               state_d = state_q;
            end
         end
         RUN: begin
            acc_d = sum_s;
            if (k_q == LAST) begin
               c_d[cij_s] = sum_s;
               k_d        = {CW{1'b0}};
               if (j_q == LAST) begin
                  j_d = {CW{1'b0}};
                  if (i_q == LAST) begin
                     i_d     = {CW{1'b0}};
                     state_d = DONE;
                  end else begin
                     i_d = i_q + 1'b1;
                  end
               end else begin
                  j_d = j_q + 1'b1;
               end
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Reads see the pre-edge storage, so a same-edge write is not visible.
      if (bus.arready) begin
         if (bus.araddr == ADDR_CTRL) begin
            rdata_d = {29'd0, sgn_q, done_q, busy_q};
         end else if (bus.araddr >= C_BASE && bus.araddr < C_BASE + 32'(N)) begin
            if (sgn_q) begin
               rdata_d = 32'($signed(c_q[IW'(bus.araddr - C_BASE)]));
            end else begin
               rdata_d = 32'(c_q[IW'(bus.araddr - C_BASE)]);
            end
         end else begin
            rdata_d = 32'd0;
         end
      end else begin
         rdata_d = rdata_q;
      end
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and storage registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         for (int n = 0; n < N; n++) begin
            a_q[n] <= {DATA_W{1'b0}};
            b_q[n] <= {DATA_W{1'b0}};
            c_q[n] <= {ACC_W{1'b0}};
         end
         acc_q      <= {ACC_W{1'b0}};
         i_q        <= {CW{1'b0}};
         j_q        <= {CW{1'b0}};
         k_q        <= {CW{1'b0}};
         acc_mode_q <= 1'b0;
         sgn_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rdata_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         c_q        <= c_d;
         acc_q      <= acc_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         acc_mode_q <= acc_mode_d;
         sgn_q      <= sgn_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_mxu_seq.sv
// Directed bench for mxu_seq; read results are checked by a queue-based monitor.
module tb_mxu_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;
   logic rd_seen = 1'b0;
   logic [31:0] exp_q [$];
   string       name_q [$];

   mxu_seq_if #(.DATA_W(8)) bus ();
   mxu_seq #(.SIZE(4), .DATA_W(8), .ACC_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Monitor: remember which edges carried a read, compare on the following negedge.
   always @(posedge clk) rd_seen <= bus.arready && !reset;

   always @(negedge clk) begin
      if (rd_seen) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_read", bus.rdata, 32'hDEAD_BEEF);
         end else begin
            chk(name_q.pop_front(), bus.rdata, exp_q.pop_front());
         end
      end
   end

   task automatic wr(input logic [31:0] addr, input logic [7:0] d);
      bus.awaddr = addr; bus.wdata = d; bus.wready = 1'b1;
      @(negedge clk);
      bus.wready = 1'b0;
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
      bus.araddr = addr; bus.arready = 1'b1;
      exp_q.push_back(exp); name_q.push_back(name);
      @(negedge clk);
      bus.arready = 1'b0;
   endtask

   // Start a run, optionally read STATUS on the start edge and/or poke the bus during RUN.
   task automatic run(input logic [7:0] ctrl, input bit inject, input bit rd_same,
                      input logic [31:0] old_c33);
      int cnt;
      bus.awaddr = 32'd0; bus.wdata = ctrl; bus.wready = 1'b1;
      if (rd_same) begin
         bus.araddr = 32'd0; bus.arready = 1'b1;
         exp_q.push_back(32'h2); name_q.push_back("rd_same_edge_status");
      end
      @(negedge clk);
      bus.wready = 1'b0; bus.arready = 1'b0;
      cnt = 0;
      while (bus.busy && cnt < 200) begin
         bus.wready = 1'b0; bus.arready = 1'b0;
         if (inject && cnt == 5) begin
            bus.awaddr = 32'd2; bus.wdata = 8'd9; bus.wready = 1'b1;
         end else if (inject && cnt == 6) begin
            bus.awaddr = 32'd0; bus.wdata = 8'd1; bus.wready = 1'b1;
         end else if (inject && cnt == 10) begin
            bus.araddr = 32'd16; bus.arready = 1'b1;
            exp_q.push_back(old_c33); name_q.push_back("c33_old_during_run");
         end
         cnt++;
         @(negedge clk);
      end
      bus.wready = 1'b0; bus.arready = 1'b0;
      chk("run_len", 32'(cnt), 32'd64);
      chk("done_after_run", 32'(bus.done), 32'd1);
      chk("busy_after_run", 32'(bus.busy), 32'd0);
   endtask

   logic [7:0] am [16] = '{8'd5, 8'd2, 8'd6, 8'd1, 8'd0, 8'd6, 8'd2, 8'd0,
                           8'd3, 8'd8, 8'd1, 8'd4, 8'd1, 8'd8, 8'd5, 8'd6};
   logic [7:0] bm [16] = '{8'd7, 8'd5, 8'd8, 8'd0, 8'd1, 8'd8, 8'd2, 8'd6,
                           8'd9, 8'd4, 8'd3, 8'd8, 8'd5, 8'd3, 8'd7, 8'd9};

   initial begin
      bus.wdata = 8'd0; bus.awaddr = 32'd0; bus.wready = 1'b0;
      bus.araddr = 32'd0; bus.arready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      chk("busy_reset", 32'(bus.busy), 32'd0);
      chk("done_reset", 32'(bus.done), 32'd0);
      rd(32'd0, 32'd0, "status_reset");
      rd(32'd1, 32'd0, "c00_reset");

      // Unsigned overwrite
      for (int n = 0; n < 16; n++) begin
         wr(32'd2 + 32'(n), am[n]);
         wr(32'd18 + 32'(n), bm[n]);
      end
      run(8'd1, 1'b0, 1'b0, 32'd0);
      rd(32'd1, 32'd96, "c00");
      rd(32'd2, 32'd68, "c01");
      rd(32'd6, 32'd56, "c11");
      rd(32'd8, 32'd52, "c13");
      rd(32'd9, 32'd58, "c20");
      rd(32'd16, 32'd142, "c33");
      rd(32'd0, 32'h2, "status_done");
      rd(32'd40, 32'd0, "unmapped_read");

      // Accumulate
      run(8'd3, 1'b0, 1'b0, 32'd0);
      rd(32'd1, 32'd192, "c00_acc");
      rd(32'd16, 32'd284, "c33_acc");

      // Writes during RUN are ignored; start carries a same-edge STATUS read
      run(8'd1, 1'b1, 1'b1, 32'd284);
      rd(32'd1, 32'd96, "c00_after_ignored_writes");
      rd(32'd16, 32'd142, "c33_after_ignored_writes");

      // Signed vs unsigned on 0xFF * 2
      for (int n = 0; n < 16; n++) begin
         wr(32'd2 + 32'(n), 8'd0);
         wr(32'd18 + 32'(n), 8'd0);
      end
      wr(32'd2, 8'hFF);
      wr(32'd18, 8'd2);
      wr(32'd0, 8'd4);
      chk("ctrl_no_start_idle", 32'(bus.busy), 32'd0);
      run(8'd5, 1'b0, 1'b0, 32'd0);
      rd(32'd1, 32'hFFFF_FFFE, "c00_signed");
      rd(32'd2, 32'd0, "c01_signed");
      rd(32'd0, 32'h6, "status_signed");
      run(8'd1, 1'b0, 1'b0, 32'd0);
      rd(32'd1, 32'h0000_01FE, "c00_unsigned");

      // Reset during RUN
      wr(32'd0, 8'd1);
      repeat (10) @(negedge clk);
      chk("busy_mid_run", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("busy_after_reset", 32'(bus.busy), 32'd0);
      chk("done_after_reset", 32'(bus.done), 32'd0);
      reset = 1'b0;
      rd(32'd1, 32'd0, "c00_cleared");
      rd(32'd16, 32'd0, "c33_cleared");
      rd(32'd0, 32'd0, "status_cleared");

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
